otter_stim_sequencer: RTL and testbench
=======================================

// Module: otter_stim_sequencer
// PURPOSE
// - Synthesisable stimulus sequencer for OTTER_Wrapper benches and on-board self-test.
// - Holds the DUT in reset (drives BTNC) for a programmable time, then steps SWITCHES through NUM_STEPS patterns.
// - Counts pipeline stall and branch-taken events, for CPI and hazard checks without $display.
// PARAMETERS
// - RST_CYCLES   30    DUT reset hold length in CLK cycles (>=1); 30 x 20ns = 600ns
// - SW_WIDTH     16    width of the SWITCHES bus
// - NUM_STEPS    4     number of switch patterns (>=1)
// - STEP_CYCLES  1000  CLK cycles each pattern is held (>=1)
// - CNT_WIDTH    32    width of each event counter
// PORTS
// - CLK         in   1                    system clock, rising edge
// - RST_N       in   1                    asynchronous active-low reset
// - START       in   1                    start/restart pulse, sampled in IDLE and DONE only
// - PATTERNS    in   SW_WIDTH*NUM_STEPS   pattern k = PATTERNS[k*SW_WIDTH +: SW_WIDTH]
// - STALL_EVT   in   1                    DUT load-use stall indication, 1 per stalled cycle
// - BRANCH_EVT  in   1                    DUT branch-taken indication, 1 per cycle
// - DUT_RST     out  1                    active-high DUT reset (to BTNC)
// - SWITCHES    out  SW_WIDTH             registered pattern to DUT
// - STEP_IDX    out  $clog2(NUM_STEPS)+1  index of the current pattern
// - DONE        out  1                    sequence complete
// - STALL_CNT   out  CNT_WIDTH            stall events counted in RUN
// - BRANCH_CNT  out  CNT_WIDTH            branch events counted in RUN
// BEHAVIOUR
// - Reset (RST_N=0, async): state=IDLE, DUT_RST=1, SWITCHES=0, STEP_IDX=0, DONE=0, both counters=0.
// - All outputs are registered. No combinational path from input to output.
// - FSM states: IDLE, HOLD, RUN, FIN.
// - IDLE: DUT_RST=1. START=1 -> HOLD; hold counter=0; both event counters=0.
// - HOLD: DUT_RST=1 for exactly RST_CYCLES cycles after the START edge.
//   - On the last HOLD edge: DUT_RST<=0, SWITCHES<=pattern 0, STEP_IDX<=0, step counter=0 -> RUN.
// - RUN: each pattern is held STEP_CYCLES cycles.
//   - At step end with STEP_IDX<NUM_STEPS-1: STEP_IDX++ and SWITCHES<=next pattern, on the same edge.
//   - At the end of the last step: -> FIN, DONE<=1. SWITCHES keeps the last pattern.
// - PATTERNS is sampled on each load edge, not latched at START.
// - FIN: DONE=1, DUT_RST=0. START=1 -> HOLD (DUT_RST<=1, DONE<=0, counters cleared).
// - START is ignored in HOLD and RUN.
// - Event counters: increment only in RUN, on cycles where the event is 1.
//   - STALL and BRANCH on the same cycle both increment.
//   - Saturate at all-ones; never wrap.
// - Internal counters are sized $clog2(param)+1 and compare against param-1; no off-by-one at param=1.
// - RST_N low mid-sequence: immediate return to reset values; a fresh START is required.
// CONFIGURATION
// - OTTER_STIM_LOOP_EN defined:
//   - After the last step, STEP_IDX<=0 and SWITCHES<=pattern 0; stays in RUN.
//   - DONE never asserts. Counters keep accumulating (saturating).
// - Not defined: single pass ending in FIN as above.
// TESTING (RST_CYCLES=4, STEP_CYCLES=3, NUM_STEPS=2, CNT_WIDTH=32, patterns 0x00A5, 0x5A00)
// - Reset release, then START for 1 cycle at edge 0 -> DUT_RST=1 through edge 4; 0 after edge 4, with SWITCHES=0x00A5 on that same edge.
// - Continue -> SWITCHES=0x00A5 / STEP_IDX=0 for 3 cycles, 0x5A00 / 1 for 3 cycles, then DONE=1 with SWITCHES=0x5A00 held.
// - STALL_EVT=1 for 5 RUN cycles and 2 IDLE cycles; BRANCH_EVT=1 on 2 of those RUN cycles -> STALL_CNT=5, BRANCH_CNT=2.
// - CNT_WIDTH=4, STEP_CYCLES=40, STALL_EVT held 1 throughout RUN -> STALL_CNT stops at 15.
// - RST_N low 2 cycles into step 1 -> DUT_RST=1, SWITCHES=0, STEP_IDX=0 immediately (before next edge); START in FIN restarts from HOLD.
// - OTTER_STIM_LOOP_EN defined -> after 0x5A00, SWITCHES=0x00A5 / STEP_IDX=0; DONE stays 0 for 20 steps.

Source files
------------

// File: rtl/otter_stim_sequencer.sv
// otter_stim_sequencer
// Stimulus sequencer for OTTER_Wrapper benches and on-board self-test.
// It holds the DUT in reset (DUT_RST drives BTNC) for RST_CYCLES clocks after
// START. It then steps SWITCHES through NUM_STEPS patterns, holding each one
// for STEP_CYCLES clocks. While running it counts stall and branch-taken
// events so that CPI and hazard behaviour can be read without $display.
//
// Configuration macro: OTTER_STIM_LOOP_EN
//   defined   : after the last step, wrap to pattern 0 and keep running (DONE never set)
//   undefined : single pass, ending in FIN with DONE=1
//
// Ports
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   START       in   start/restart pulse, honoured in IDLE and FIN only
//   PATTERNS    in   pattern k = PATTERNS[k*SW_WIDTH +: SW_WIDTH], sampled on each load edge
//   STALL_EVT   in   DUT load-use stall indication, one per stalled cycle
//   BRANCH_EVT  in   DUT branch-taken indication, one per cycle
//   DUT_RST     out  active-high DUT reset (registered)
//   SWITCHES    out  current pattern (registered)
//   STEP_IDX    out  index of the current pattern (registered)
//   DONE        out  sequence complete (registered)
//   STALL_CNT   out  saturating count of stall events seen in RUN
//   BRANCH_CNT  out  saturating count of branch events seen in RUN
module otter_stim_sequencer #(
  parameter int RST_CYCLES  = 30,
  parameter int SW_WIDTH    = 16,
  parameter int NUM_STEPS   = 4,
  parameter int STEP_CYCLES = 1000,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          START,
  input  logic [SW_WIDTH*NUM_STEPS-1:0] PATTERNS,
  input  logic                          STALL_EVT,
  input  logic                          BRANCH_EVT,
  output logic                          DUT_RST,
  output logic [SW_WIDTH-1:0]           SWITCHES,
  output logic [$clog2(NUM_STEPS):0]    STEP_IDX,
  output logic                          DONE,
  output logic [CNT_WIDTH-1:0]          STALL_CNT,
  output logic [CNT_WIDTH-1:0]          BRANCH_CNT
);

  localparam int IDX_W  = $clog2(NUM_STEPS) + 1;
  localparam int HOLD_W = $clog2(RST_CYCLES) + 1;
  localparam int STEP_W = $clog2(STEP_CYCLES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_FIN} state_t;

  state_t              r_state, w_nextState;
  logic                r_dutRst, w_nDutRst;
  logic [SW_WIDTH-1:0] r_sw, w_nSw;
  logic [IDX_W-1:0]    r_idx, w_nIdx;
  logic                r_done, w_nDone;
  logic [HOLD_W-1:0]   r_hold, w_nHold;
  logic [STEP_W-1:0]   r_step, w_nStep;
  logic [CNT_WIDTH-1:0] r_stall, w_nStall;
  logic [CNT_WIDTH-1:0] r_branch, w_nBranch;

  logic                w_holdLast;
  logic                w_stepLast;
  logic                w_lastIdx;
  logic [IDX_W-1:0]    w_patSel;
  logic [SW_WIDTH-1:0] w_patSelected;

  // Counters compare against param-1 so a parameter of 1 still gives one cycle.
  assign w_holdLast = (r_hold == HOLD_W'(RST_CYCLES - 1));
  assign w_stepLast = (r_step == STEP_W'(STEP_CYCLES - 1));
  assign w_lastIdx  = (r_idx == IDX_W'(NUM_STEPS - 1));

  // The pattern loaded at a step boundary: the next one, or pattern 0 when wrapping.
  assign w_patSel      = w_lastIdx ? '0 : r_idx + IDX_W'(1);
  assign w_patSelected = PATTERNS[int'(w_patSel)*SW_WIDTH +: SW_WIDTH];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE:  if (START) w_nextState = S_HOLD;
      S_HOLD:  if (w_holdLast) w_nextState = S_RUN;
      S_RUN: begin
`ifdef OTTER_STIM_LOOP_EN
        w_nextState = S_RUN;
`else
        if (w_stepLast && w_lastIdx) w_nextState = S_FIN;
`endif
      end
      S_FIN:   if (START) w_nextState = S_HOLD;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Next values of every registered output and internal counter.
  always_comb begin
    w_nDutRst = r_dutRst;
    w_nSw     = r_sw;
    w_nIdx    = r_idx;
    w_nDone   = r_done;
    w_nHold   = r_hold;
    w_nStep   = r_step;
    w_nStall  = r_stall;
    w_nBranch = r_branch;
    unique case (r_state)
      S_IDLE, S_FIN: begin
        if (START) begin
          w_nDutRst = 1'b1;
          w_nDone   = 1'b0;
          w_nHold   = '0;
          w_nStall  = '0;
          w_nBranch = '0;
        end
      end
      S_HOLD: begin
        if (w_holdLast) begin
          w_nDutRst = 1'b0;
          w_nSw     = PATTERNS[SW_WIDTH-1:0];
          w_nIdx    = '0;
          w_nStep   = '0;
        end else begin
          w_nHold = r_hold + HOLD_W'(1);
        end
      end
      S_RUN: begin
        // Event counters saturate at all-ones rather than wrapping.
        if (STALL_EVT && (r_stall != '1))   w_nStall  = r_stall + CNT_WIDTH'(1);
        if (BRANCH_EVT && (r_branch != '1)) w_nBranch = r_branch + CNT_WIDTH'(1);
        if (w_stepLast) begin
          w_nStep = '0;
          if (!w_lastIdx) begin
            w_nIdx = w_patSel;
            w_nSw  = w_patSelected;
          end else begin
`ifdef OTTER_STIM_LOOP_EN
            w_nIdx = w_patSel;
            w_nSw  = w_patSelected;
`else
            w_nDone = 1'b1;
`endif
          end
        end else begin
          w_nStep = r_step + STEP_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dutRst <= 1'b1;
      r_sw     <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_hold   <= '0;
      r_step   <= '0;
      r_stall  <= '0;
      r_branch <= '0;
    end else begin
      r_dutRst <= w_nDutRst;
      r_sw     <= w_nSw;
      r_idx    <= w_nIdx;
      r_done   <= w_nDone;
      r_hold   <= w_nHold;
      r_step   <= w_nStep;
      r_stall  <= w_nStall;
      r_branch <= w_nBranch;
    end
  end

  assign DUT_RST    = r_dutRst;
  assign SWITCHES   = r_sw;
  assign STEP_IDX   = r_idx;
  assign DONE       = r_done;
  assign STALL_CNT  = r_stall;
  assign BRANCH_CNT = r_branch;

endmodule

// File: tb/tb_otter_stim_sequencer.sv
`timescale 1ns/1ps
// tb_otter_stim_sequencer
// Scoreboard bench for otter_stim_sequencer. A reference model describes the
// expected outputs in terms of "clock edges since START". It pushes one
// expectation per clock, and a monitor pops and compares each one after the
// edge. A second instance with 4-bit counters exercises saturation.
module tb_otter_stim_sequencer;

  localparam int RSTC    = 4;
  localparam int NSTEP   = 2;
  localparam int STEPC   = 3;
  localparam int SWW     = 16;
  localparam int RUN_END = RSTC + NSTEP*STEPC;
`ifdef OTTER_STIM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        STALL_EVT = 1'b0;
  logic        BRANCH_EVT = 1'b0;
  logic [31:0] PATTERNS = 32'h5A00_00A5;

  logic        dutRst;
  logic [15:0] switches;
  logic [1:0]  stepIdx;
  logic        done;
  logic [31:0] stallCnt;
  logic [31:0] branchCnt;

  logic        start2 = 1'b0;
  logic        stall2 = 1'b1;
  logic        branch2 = 1'b0;
  logic        dutRst2;
  logic [15:0] sw2;
  logic [1:0]  idx2;
  logic        done2;
  logic [3:0]  stallCnt2;
  logic [3:0]  branchCnt2;

  int checkCount = 0;
  int passCount  = 0;
  int edgeNo     = -100;
  int b2Count    = 0;
  bit simDone    = 1'b0;

  otter_stim_sequencer #(
    .RST_CYCLES(RSTC), .SW_WIDTH(SWW), .NUM_STEPS(NSTEP),
    .STEP_CYCLES(STEPC), .CNT_WIDTH(32)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .PATTERNS(PATTERNS),
    .STALL_EVT(STALL_EVT), .BRANCH_EVT(BRANCH_EVT), .DUT_RST(dutRst),
    .SWITCHES(switches), .STEP_IDX(stepIdx), .DONE(done),
    .STALL_CNT(stallCnt), .BRANCH_CNT(branchCnt)
  );

  otter_stim_sequencer #(
    .RST_CYCLES(RSTC), .SW_WIDTH(SWW), .NUM_STEPS(NSTEP),
    .STEP_CYCLES(40), .CNT_WIDTH(4)
  ) dutSat (
    .CLK(CLK), .RST_N(RST_N), .START(start2), .PATTERNS(PATTERNS),
    .STALL_EVT(stall2), .BRANCH_EVT(branch2), .DUT_RST(dutRst2),
    .SWITCHES(sw2), .STEP_IDX(idx2), .DONE(done2),
    .STALL_CNT(stallCnt2), .BRANCH_CNT(branchCnt2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dutRst;
    logic [15:0] sw;
    logic [1:0]  idx;
    logic        done;
    logic [31:0] stall;
    logic [31:0] branch;
    bit          swCheck;
  } exp_t;

  exp_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  // Drives one cycle of inputs on the falling edge; edgeNo names the rising edge they feed.
  task automatic applyStimulus(input logic start, input logic stall, input logic branch, input logic rstn);
    @(negedge CLK);
    edgeNo++;
    RST_N      = rstn;
    START      = start;
    STALL_EVT  = stall;
    BRANCH_EVT = branch;
    start2     = (edgeNo == 0);
    branch2    = ($urandom_range(0, 7) == 0);
    if (branch2 && edgeNo >= RSTC + 1 && edgeNo <= RSTC + 80) b2Count++;
  endtask

  // Reference model: the phase follows from the number of edges since START.
  bit          mStarted = 1'b0;
  int          mE = 0;
  logic [15:0] mSw;
  logic [1:0]  mIdx;
  logic [31:0] mStall;
  logic [31:0] mBranch;
  exp_t        modelX;
  int          mR;
  int          mK;
  bit          mDone;

  always @(posedge CLK) begin
    if (!RST_N) begin
      mStarted = 1'b0;
      mE       = 0;
      mSw      = '0;
      mIdx     = '0;
      mStall   = '0;
      mBranch  = '0;
    end else begin
      mDone = mStarted && !LOOP && (mE >= RUN_END);
      if ((!mStarted || mDone) && START) begin
        mStarted = 1'b1;
        mE       = 0;
        mStall   = '0;
        mBranch  = '0;
      end else if (mStarted) begin
        mE++;
        if (mE > RSTC && (LOOP || mE <= RUN_END)) begin
          if (STALL_EVT && mStall != 32'hFFFF_FFFF)   mStall++;
          if (BRANCH_EVT && mBranch != 32'hFFFF_FFFF) mBranch++;
        end
        if (mE >= RSTC) begin
          mR = mE - RSTC;
          if ((LOOP || mR < NSTEP*STEPC) && (mR % STEPC == 0)) begin
            mK   = (mR / STEPC) % NSTEP;
            mIdx = 2'(mK);
            mSw  = PATTERNS[mK*SWW +: SWW];
          end
        end
      end
    end
    modelX.dutRst  = !mStarted || (mE < RSTC);
    modelX.done    = mStarted && !LOOP && (mE >= RUN_END);
    modelX.sw      = mSw;
    modelX.idx     = mIdx;
    modelX.stall   = mStall;
    modelX.branch  = mBranch;
    modelX.swCheck = !mStarted || (mE >= RSTC);
    expQ.push_back(modelX);
  end

  exp_t monX;

  always @(posedge CLK) begin
    #1;
    if (!simDone) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL scoreboard: no expectation queued at %0t", $time);
      end else begin
        monX = expQ.pop_front();
        checkOutput("DUT_RST", 32'(dutRst), 32'(monX.dutRst));
        checkOutput("DONE", 32'(done), 32'(monX.done));
        checkOutput("STALL_CNT", stallCnt, monX.stall);
        checkOutput("BRANCH_CNT", branchCnt, monX.branch);
        if (monX.swCheck) begin
          checkOutput("SWITCHES", 32'(switches), 32'(monX.sw));
          checkOutput("STEP_IDX", 32'(stepIdx), 32'(monX.idx));
        end
      end
    end
  end

  int rstLeft = 0;

  initial begin
    repeat (3) applyStimulus(0, 0, 0, 0);

    // Directed run: stall seen on two IDLE cycles, then five RUN cycles with two branches.
    repeat (2) applyStimulus(0, 1, 0, 1);
    edgeNo = -1;
    applyStimulus(1, 0, 0, 1);
    repeat (RSTC) applyStimulus(0, 0, 0, 1);
    for (int k = RSTC + 1; k <= RUN_END; k++)
      applyStimulus(0, k <= RSTC + 5, (k == RSTC + 2) || (k == RSTC + 4), 1);
    for (int k = 0; k < 80; k++) begin
      applyStimulus(0, 0, 0, 1);
      if (edgeNo == RUN_END + 1) begin
        #1;
        checkOutput("run1 STALL_CNT", stallCnt, 32'd5);
        checkOutput("run1 BRANCH_CNT", branchCnt, 32'd2);
        checkOutput("run1 DONE", 32'(done), LOOP ? 32'd0 : 32'd1);
        checkOutput("run1 SWITCHES", 32'(switches), LOOP ? 32'h00A5 : 32'h5A00);
      end
      if (edgeNo == RSTC + 81) begin
        #1;
        checkOutput("sat STALL_CNT", 32'(stallCnt2), 32'd15);
        checkOutput("sat BRANCH_CNT", 32'(branchCnt2), (b2Count > 15) ? 32'd15 : 32'(b2Count));
        checkOutput("sat DONE", 32'(done2), LOOP ? 32'd0 : 32'd1);
      end
    end

    // START from FIN restarts (ignored while looping).
    applyStimulus(1, 0, 0, 1);
    repeat (20) applyStimulus(0, $urandom_range(0, 1), $urandom_range(0, 1), 1);

    // Reset two cycles into step 1 must clear everything before the next edge.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(1, 0, 0, 1);
    repeat (RSTC + STEPC + 2) applyStimulus(0, 1, 1, 1);
    #1;
    checkOutput("pre-reset STEP_IDX", 32'(stepIdx), 32'd1);
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("async DUT_RST", 32'(dutRst), 32'd1);
    checkOutput("async SWITCHES", 32'(switches), 32'd0);
    checkOutput("async STEP_IDX", 32'(stepIdx), 32'd0);
    checkOutput("async DONE", 32'(done), 32'd0);
    checkOutput("async STALL_CNT", stallCnt, 32'd0);
    checkOutput("async BRANCH_CNT", branchCnt, 32'd0);
    applyStimulus(0, 0, 0, 0);
    repeat (3) applyStimulus(0, 1, 1, 1);

    // Randomised traffic: restarts, pattern changes mid-run and occasional resets.
    for (int c = 0; c < 1500; c++) begin
      if (rstLeft > 0) rstLeft--;
      else if ($urandom_range(0, 199) == 0) rstLeft = 2;
      if ($urandom_range(0, 7) == 0) PATTERNS = $urandom;
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 1), $urandom_range(0, 1), rstLeft == 0);
    end

    repeat (2) applyStimulus(0, 0, 0, 1);
    simDone = 1'b1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
